pe_feeder: RTL

Sequencer that drives one `proElement` MAC lane from the transmit side of the PE stream protocol. On `start` it issues a header beat carrying the term count, streams `length` weight/input pairs fetched from two synchronous-read memories, and holds bias on `b`. It then waits for the PE's `done_flag`, captures `pe_out` as the neuron result, and returns to idle. One feeder instance sits in front of each PE in the layer array; the layer controller issues `start` and collects `result`.

---
 rtl/pe_feeder_if.sv | 37 +++
 rtl/pe_feeder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pe_feeder_if.sv
// PE feeder bus: layer-controller request, operand memories, PE lane and result.
interface pe_feeder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic [9:0]        length;
    logic [31:0]       bias;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       w_rdata;
    logic [31:0]       x_rdata;
    logic              head;
    logic              valid;
    logic [31:0]       w;
    logic [31:0]       x;
    logic [31:0]       b;
    logic              done_flag;
    logic [31:0]       pe_out;
    logic [31:0]       result;
    logic              result_valid;
    logic              busy;
    logic              error;

    // Feeder side
    modport master (
        input  start, length, bias, w_rdata, x_rdata, done_flag, pe_out,
        output mem_addr, mem_rd, head, valid, w, x, b,
               result, result_valid, busy, error
    );

    // Environment side: controller, memories and PE
    modport slave (
        output start, length, bias, w_rdata, x_rdata, done_flag, pe_out,
        input  mem_addr, mem_rd, head, valid, w, x, b,
               result, result_valid, busy, error
    );
endinterface

// File: rtl/pe_feeder.sv
// Sequencer feeding one PE MAC lane: header beat, weight/input stream, result capture.
module pe_feeder #(
    parameter int unsigned N_MAX   = 784,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic         clock,
    input logic         reset,
    pe_feeder_if.master bus
);
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TMO_W  = 10;

    typedef enum logic [2:0] {IDLE, HEADER, STREAM, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                head_q, head_d;
    logic                valid_q, valid_d;
    logic                mem_rd_q, mem_rd_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic                start_ok_c;
    logic                rd_more_c;

    assign start_ok_c = (bus.length != '0) && (bus.length <= LEN_W'(N_MAX));
    assign rd_more_c  = (idx_q < len_q);

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            beat_q         <= '0;
            tmo_q          <= '0;
            b_q            <= '0;
            x_q            <= '0;
            result_q       <= '0;
            mem_addr_q     <= '0;
            head_q         <= 1'b0;
            valid_q        <= 1'b0;
            mem_rd_q       <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            beat_q         <= beat_d;
            tmo_q          <= tmo_d;
            b_q            <= b_d;
            x_q            <= x_d;
            result_q       <= result_d;
            mem_addr_q     <= mem_addr_d;
            head_q         <= head_d;
            valid_q        <= valid_d;
            mem_rd_q       <= mem_rd_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        beat_d         = beat_q;
        tmo_d          = tmo_q;
        b_d            = b_q;
        x_d            = '0;
        result_d       = result_q;
        mem_addr_d     = mem_addr_q;
        head_d         = 1'b0;
        valid_d        = 1'b0;
        mem_rd_d       = 1'b0;
        result_valid_d = 1'b0;
        error_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_ok_c) begin
                        state_d    = HEADER;
                        len_d      = bus.length;
                        b_d        = bus.bias;
                        x_d        = DATA_W'(bus.length);
                        head_d     = 1'b1;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = '0;
                        idx_d      = LEN_W'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            HEADER: begin
                state_d = STREAM;
                valid_d = 1'b1;
                beat_d  = '0;
                if (rd_more_c) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = ADDR_W'(idx_q);
                    idx_d      = idx_q + LEN_W'(1);
                end
            end
            STREAM: begin
                if (beat_q == len_q - LEN_W'(1)) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end else begin
                    valid_d = 1'b1;
                    beat_d  = beat_q + LEN_W'(1);
                    if (rd_more_c) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = ADDR_W'(idx_q);
                        idx_d      = idx_q + LEN_W'(1);
                    end
                end
            end
            WAIT: begin
                if (bus.done_flag) begin
                    result_d       = bus.pe_out;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Data beats pass the synchronous-read memory outputs straight through to the PE
    assign bus.w            = valid_q ? bus.w_rdata : '0;
    assign bus.x            = valid_q ? bus.x_rdata : x_q;
    assign bus.b            = b_q;
    assign bus.head         = head_q;
    assign bus.valid        = valid_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.error        = error_q;
endmodule
